// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch unit.
package fetch_unit_pkg;

   localparam int unsigned XLen = 16;
   localparam logic [XLen-1:0] ResetPcDefault = 16'h0000;

   typedef enum logic [1:0] {
      StIdle,
      StWait,
      StDrop
   } fetch_state_e;

endpackage

// File: rtl/fetch_unit_prefetch_fifo.sv
// First-word-fall-through prefetch buffer holding {pc, inst} entries.
module prefetch_fifo #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned WIDTH = 32
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    push,
   input  logic                    pop,
   input  logic                    flush,
   input  logic [WIDTH-1:0]        wdata,
   output logic [WIDTH-1:0]        rdata,
   output logic [$clog2(DEPTH):0]  count
);

   localparam int unsigned PtrW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
   logic [PtrW:0]    count_q;

   assign rdata = mem_q[rd_ptr_q];
   assign count = count_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else if (push && !flush) begin
         mem_q[wr_ptr_q] <= wdata;
      end
   end

   // Flush wins over any push/pop in the same cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else if (flush) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         if (push && !pop)      count_q <= count_q + 1'b1;
         else if (pop && !push) count_q <= count_q - 1'b1;
      end
   end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: one outstanding memory request feeding a prefetch buffer,
// with redirect flush and halt.
module fetch_unit
   import fetch_unit_pkg::*;
#(
   parameter int unsigned     DEPTH    = 4,
   parameter logic [XLen-1:0] RESET_PC = ResetPcDefault
) (
   input  logic            clk,
   input  logic            rst,
   output logic            imem_req,
   output logic [XLen-1:0] imem_addr,
   input  logic            imem_ack,
   input  logic [XLen-1:0] imem_data,
   output logic            inst_valid,
   output logic [XLen-1:0] inst,
   output logic [XLen-1:0] inst_pc,
   input  logic            inst_ready,
   input  logic            redirect,
   input  logic [XLen-1:0] redirect_pc,
   input  logic            halt
);

   localparam int unsigned CntW = $clog2(DEPTH) + 1;

   fetch_state_e    state_q, state_d;
   logic [XLen-1:0] fpc_q, fpc_d;
   logic [XLen-1:0] addr_q, addr_d;
   logic [CntW-1:0] count, cnt_next;
   logic [2*XLen-1:0] head;
   logic            push, pop, issue_ok;

   assign inst_valid = (count != '0);
   assign inst_pc    = head[2*XLen-1:XLen];
   assign inst       = head[XLen-1:0];
   assign imem_req   = (state_q != StIdle);
   assign imem_addr  = addr_q;

   assign push = (state_q == StWait) & imem_ack & ~redirect;
   assign pop  = inst_valid & inst_ready & ~redirect;

   // Issue only if the returning word is guaranteed a slot.
   assign cnt_next = count + CntW'(push) - CntW'(pop);
   assign issue_ok = ~halt & (cnt_next < CntW'(DEPTH));

   prefetch_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (2 * XLen)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (pop),
      .flush (redirect),
      .wdata ({fpc_q, imem_data}),
      .rdata (head),
      .count (count)
   );

   always_comb begin
      state_d = state_q;
      fpc_d   = fpc_q;
      addr_d  = addr_q;
      if (redirect) fpc_d = redirect_pc;
      unique case (state_q)
         StIdle: begin
            if (!redirect && issue_ok) begin
               state_d = StWait;
               addr_d  = fpc_q;
            end
         end
         StWait: begin
            if (redirect) begin
               state_d = imem_ack ? StIdle : StDrop;
            end else if (imem_ack) begin
               fpc_d = fpc_q + XLen'(2);
               if (issue_ok) addr_d = fpc_q + XLen'(2);
               else          state_d = StIdle;
            end
         end
         StDrop: begin
            if (imem_ack) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
         fpc_q   <= RESET_PC;
         addr_q  <= '0;
      end else begin
         state_q <= state_d;
         fpc_q   <= fpc_d;
         addr_q  <= addr_d;
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a latency-configurable memory responder.
module tb_fetch_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        imem_req;
   logic [15:0] imem_addr;
   logic        imem_ack;
   logic [15:0] imem_data;
   logic        inst_valid;
   logic [15:0] inst;
   logic [15:0] inst_pc;
   logic        inst_ready;
   logic        redirect;
   logic [15:0] redirect_pc;
   logic        halt;

   int unsigned lat;
   int unsigned wait_cnt;
   logic        ack_force;
   int          n_checks = 0;
   int          n_fail = 0;

   always #5 clk = ~clk;

   fetch_unit #(
      .DEPTH    (4),
      .RESET_PC (16'h0000)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_ack    (imem_ack),
      .imem_data   (imem_data),
      .inst_valid  (inst_valid),
      .inst        (inst),
      .inst_pc     (inst_pc),
      .inst_ready  (inst_ready),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .halt        (halt)
   );

   // Memory: mem[a] = a ^ A5A5, ack after 'lat' cycles of live request.
   always_comb imem_data = imem_addr ^ 16'hA5A5;
   always_comb imem_ack  = ack_force | (imem_req & (wait_cnt == lat));

   always @(posedge clk or posedge rst) begin
      if (rst)                       wait_cnt <= 0;
      else if (!imem_req || imem_ack) wait_cnt <= 0;
      else                           wait_cnt <= wait_cnt + 1;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic reset_dut();
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
   endtask

   task automatic wait_valid(input string tag);
      for (int i = 0; i < 20; i++) begin
         if (inst_valid) break;
         step();
      end
      check(tag, {31'd0, inst_valid}, 32'd1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      logic [15:0] a;
      logic [15:0] exp_pc [3];
      exp_pc = '{16'hFFFC, 16'hFFFE, 16'h0000};

      rst = 1'b1; halt = 1'b0; inst_ready = 1'b1; redirect = 1'b0;
      redirect_pc = 16'h0000; lat = 0; ack_force = 1'b0;
      #1;
      check("rst_req",   {31'd0, imem_req},   32'd0);
      check("rst_addr",  {16'd0, imem_addr},  32'd0);
      check("rst_valid", {31'd0, inst_valid}, 32'd0);
      check("rst_inst",  {16'd0, inst},       32'd0);
      check("rst_pc",    {16'd0, inst_pc},    32'd0);

      // Streaming with same-cycle ack
      step();
      rst = 1'b0;
      wait_valid("stream_first");
      for (int i = 0; i < 8; i++) begin
         a = 16'(2 * i);
         check("stream_valid", {31'd0, inst_valid}, 32'd1);
         check("stream_pc",    {16'd0, inst_pc},    {16'd0, a});
         check("stream_inst",  {16'd0, inst},       {16'd0, a ^ 16'hA5A5});
         step();
      end

      // Backpressure fills exactly DEPTH entries
      inst_ready = 1'b0;
      reset_dut();
      repeat (10) step();
      check("full_req",   {31'd0, imem_req},   32'd0);
      check("full_valid", {31'd0, inst_valid}, 32'd1);
      check("full_pc",    {16'd0, inst_pc},    32'd0);
      inst_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         check("drain_pc", {16'd0, inst_pc}, 32'(2 * i));
         if (i == 1) begin
            check("resume_req",  {31'd0, imem_req},  32'd1);
            check("resume_addr", {16'd0, imem_addr}, 32'h0008);
         end
         step();
      end

      // Redirect mid-WAIT with 3-cycle memory
      lat = 3;
      inst_ready = 1'b0;
      reset_dut();
      wait_valid("lat_first");
      step();
      redirect = 1'b1; redirect_pc = 16'h0100;
      step();
      redirect = 1'b0;
      check("drop_valid", {31'd0, inst_valid}, 32'd0);
      check("drop_req",   {31'd0, imem_req},   32'd1);
      check("drop_addr",  {16'd0, imem_addr},  32'h0002);
      inst_ready = 1'b1;
      wait_valid("drop_after");
      check("drop_pc",   {16'd0, inst_pc}, 32'h0100);
      check("drop_inst", {16'd0, inst},    32'hA4A5);

      // Redirect coincident with ack
      lat = 0;
      reset_dut();
      wait_valid("coin_first");
      redirect = 1'b1; redirect_pc = 16'h0100;
      step();
      redirect = 1'b0;
      check("coin_valid0", {31'd0, inst_valid}, 32'd0);
      check("coin_req0",   {31'd0, imem_req},   32'd0);
      step();
      check("coin_req1",   {31'd0, imem_req},   32'd1);
      check("coin_addr",   {16'd0, imem_addr},  32'h0100);
      check("coin_valid1", {31'd0, inst_valid}, 32'd0);
      step();
      check("coin_valid2", {31'd0, inst_valid}, 32'd1);
      check("coin_pc",     {16'd0, inst_pc},    32'h0100);
      check("coin_inst",   {16'd0, inst},       32'hA4A5);

      // Address wrap
      redirect = 1'b1; redirect_pc = 16'hFFFC;
      step();
      redirect = 1'b0;
      wait_valid("wrap_first");
      for (int i = 0; i < 3; i++) begin
         check("wrap_pc",   {16'd0, inst_pc}, {16'd0, exp_pc[i]});
         check("wrap_inst", {16'd0, inst},    {16'd0, exp_pc[i] ^ 16'hA5A5});
         step();
      end

      // Halt lets the outstanding request complete
      lat = 3;
      reset_dut();
      step();
      halt = 1'b1;
      wait_valid("halt_first");
      check("halt_pc",  {16'd0, inst_pc},  32'h0000);
      check("halt_req", {31'd0, imem_req}, 32'd0);
      step();
      check("halt_drained", {31'd0, inst_valid}, 32'd0);
      check("halt_idle",    {31'd0, imem_req},   32'd0);
      halt = 1'b0;
      step();
      check("unhalt_req",  {31'd0, imem_req},  32'd1);
      check("unhalt_addr", {16'd0, imem_addr}, 32'h0002);

      // Asynchronous reset mid-WAIT, then a late ack
      inst_ready = 1'b0;
      reset_dut();
      wait_valid("arst_first");
      #2;
      rst = 1'b1;
      #1;
      check("arst_req",   {31'd0, imem_req},   32'd0);
      check("arst_valid", {31'd0, inst_valid}, 32'd0);
      check("arst_inst",  {16'd0, inst},       32'd0);
      check("arst_pc",    {16'd0, inst_pc},    32'd0);
      step();
      rst = 1'b0;
      ack_force = 1'b1;
      check("late_req", {31'd0, imem_req}, 32'd0);
      step();
      ack_force = 1'b0;
      check("late_valid", {31'd0, inst_valid}, 32'd0);
      check("late_req1",  {31'd0, imem_req},   32'd1);
      check("late_addr",  {16'd0, imem_addr},  32'h0000);
      wait_valid("late_first");
      check("late_pc",   {16'd0, inst_pc}, 32'h0000);
      check("late_inst", {16'd0, inst},    32'hA5A5);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
